darkdbg_bridge: RTL

Serial debug bridge: consumes a byte-stream command protocol (fed from the UART receive path) and acts as a second initiator on the darkriscv data bus. It issues single-word reads and writes to RAM and IO, and returns response bytes on a byte-stream output. It sits beside core0 and stalls the core through `CPUHLT` while it owns the bus, so program load and memory inspection need no firmware.

---
 rtl/darkdbg_bridge.sv | 139 +++++++++++++
 1 files changed

// File: rtl/darkdbg_bridge.sv
// darkdbg_bridge: serial debug bridge issuing single-word bus reads/writes from a byte command stream
// Ports:
//   clk_i, res_i                  clock, synchronous active-high reset
//   rxdata_i/rxval_i/rxrdy_o      command byte stream in
//   txdata_o/txval_o/txrdy_i      response byte stream out
//   daddr_o/datao_o/datai_i       bus address, write data, read data
//   be_o/wr_o/rd_o/hlt_i          byte enables, write/read request, bus wait
//   cpuhlt_o                      stalls core0 while the bridge owns the bus
module darkdbg_bridge #(
    parameter int TOUT = 255
) (
    input  logic        clk_i,
    input  logic        res_i,
    input  logic [7:0]  rxdata_i,
    input  logic        rxval_i,
    output logic        rxrdy_o,
    output logic [7:0]  txdata_o,
    output logic        txval_o,
    input  logic        txrdy_i,
    output logic [31:0] daddr_o,
    output logic [31:0] datao_o,
    input  logic [31:0] datai_i,
    output logic [3:0]  be_o,
    output logic        wr_o,
    output logic        rd_o,
    input  logic        hlt_i,
    output logic        cpuhlt_o
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUSWR, BUSRD, RESP} state_t;
    state_t      state_q;
    logic        mode_q;
    logic [1:0]  cnt_q, last_q;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] addr_q, data_q, resp_q;
    logic        rxrdy_q, txval_q, wr_q, rd_q, cpuhlt_q;
    logic [3:0]  be_q;
    logic        rx_fire, tx_fire;
    assign rx_fire = rxval_i && rxrdy_q;
    assign tx_fire = txval_q && txrdy_i;
    assign wait_d  = wait_q + 8'd1;
    assign rxrdy_o  = rxrdy_q;
    assign txval_o  = txval_q;
    // Response bytes leave MSB first; the buffer shifts in zeros so TXDATA idles at 0.
    assign txdata_o = resp_q[31:24];
    assign daddr_o  = addr_q;
    assign datao_o  = data_q;
    assign be_o     = be_q;
    assign wr_o     = wr_q;
    assign rd_o     = rd_q;
    assign cpuhlt_o = cpuhlt_q;
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            cnt_q    <= 2'd0;
            last_q   <= 2'd0;
            wait_q   <= 8'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            resp_q   <= 32'd0;
            rxrdy_q  <= 1'b1;
            txval_q  <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            be_q     <= 4'd0;
            cpuhlt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (rx_fire) begin
                    cpuhlt_q <= 1'b1;
                    cnt_q    <= 2'd0;
                    if (rxdata_i == 8'h57 || rxdata_i == 8'h52) begin
                        state_q <= ADDR;
                        mode_q  <= rxdata_i == 8'h57;
                    end else begin
                        state_q <= RESP;
                        rxrdy_q <= 1'b0;
                        txval_q <= 1'b1;
                        last_q  <= 2'd0;
                        resp_q  <= {rxdata_i == 8'h50 ? 8'h06 : 8'h15, 24'd0};
                    end
                end
                ADDR: if (rx_fire) begin
                    cnt_q  <= cnt_q + 2'd1;
                    addr_q <= {addr_q[23:0], rxdata_i};
                    if (cnt_q == 2'd3) begin
                        addr_q <= {addr_q[23:0], rxdata_i[7:2], 2'b00};
                        if (mode_q) state_q <= DATA;
                        else begin
                            state_q <= BUSRD;
                            rxrdy_q <= 1'b0;
                            rd_q    <= 1'b1;
                            be_q    <= 4'hF;
                            wait_q  <= 8'd0;
                        end
                    end
                end
                DATA: if (rx_fire) begin
                    cnt_q  <= cnt_q + 2'd1;
                    data_q <= {data_q[23:0], rxdata_i};
                    if (cnt_q == 2'd3) begin
                        state_q <= BUSWR;
                        rxrdy_q <= 1'b0;
                        wr_q    <= 1'b1;
                        be_q    <= 4'hF;
                        wait_q  <= 8'd0;
                    end
                end
                BUSWR, BUSRD: begin
                    // Completion is checked before the wait limit, so HLT=0 always wins.
                    if (!hlt_i || wait_d == 8'(TOUT)) begin
                        state_q <= RESP;
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        be_q    <= 4'd0;
                        txval_q <= 1'b1;
                        cnt_q   <= 2'd0;
                        last_q  <= (!hlt_i && state_q == BUSRD) ? 2'd3 : 2'd0;
                        resp_q  <= hlt_i ? {8'h15, 24'd0} :
                                   state_q == BUSRD ? datai_i : {8'h06, 24'd0};
                    end
                    if (hlt_i) wait_q <= wait_d;
                end
                RESP: if (tx_fire) begin
                    resp_q <= {resp_q[23:0], 8'd0};
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == last_q) begin
                        state_q  <= IDLE;
                        cnt_q    <= 2'd0;
                        txval_q  <= 1'b0;
                        rxrdy_q  <= 1'b1;
                        cpuhlt_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
